ram_port_ctrl: RTL

Request/response front-end for one port of the team's dual-port RAM. Accepts valid/ready word requests from a core or bus master, drives the RAM port's enable, byte-write-enable, address and write-data, and captures the RAM's one-cycle registered read data. Responses are returned in order through a 2-entry response FIFO with backpressure. Out-of-range addresses are rejected with an error response and never reach the RAM.

---
 rtl/ram_port_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ram_port_ctrl.sv
// Single-port request/response front-end for one port of the dual-port RAM.
// Requests go to the RAM in order. Responses come back in the same order through a 2-entry FIFO.
module ram_port_ctrl #(
    parameter  int NDATA     = 64,
    parameter  int NDATABYTE = 4,
    localparam int NADDRBIT  = $clog2(NDATA)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [NDATABYTE-1:0]   i_req_wen,
    input  logic [NADDRBIT-1:0]    i_req_addr,
    input  logic [NDATABYTE*8-1:0] i_req_wdata,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [NDATABYTE*8-1:0] o_rsp_rdata,
    output logic                   o_rsp_wr,
    output logic                   o_rsp_err,
    output logic                   o_ram_en,
    output logic [NDATABYTE-1:0]   o_ram_wen,
    output logic [NADDRBIT-1:0]    o_ram_addr,
    output logic [NDATABYTE*8-1:0] o_ram_wdata,
    input  logic [NDATABYTE*8-1:0] i_ram_rdata
);

    localparam int DW     = NDATABYTE * 8;
    localparam int ADDRW1 = NADDRBIT + 1;
    localparam logic [ADDRW1-1:0] LP_NDATA = ADDRW1'(NDATA);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // A requester holds its request stable until that edge. The same rule applies to responses.

    // In-flight stage: the request accepted in the previous cycle
    logic          r_inf_valid;
    logic          r_inf_wr;
    logic          r_inf_err;

    // Response FIFO: circular buffer with 1-bit pointers
    logic [DW-1:0] r_fifo_rdata [0:1];
    logic [1:0]    r_fifo_wr;
    logic [1:0]    r_fifo_err;
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;

    logic          w_accept;
    logic          w_req_err;
    logic          w_req_wr;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_occ;
    logic          w_rsp_valid;
    logic [DW-1:0] w_push_rdata;

    // Request side
    assign w_occ       = r_count + {1'b0, r_inf_valid};
    assign w_rsp_valid = (r_count != 2'd0);
    assign w_pop       = w_rsp_valid & i_rsp_ready;
    assign o_req_ready = rst_n & ((w_occ < 2'd2) | w_pop);
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_req_err   = ({1'b0, i_req_addr} >= LP_NDATA);
    assign w_req_wr    = (i_req_wen != '0);

    // Out-of-range requests never enable the RAM.
    // Address and data pass through unqualified because the RAM ignores them while disabled.
    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_wen   = '0;
        o_ram_addr  = i_req_addr;
        o_ram_wdata = i_req_wdata;
        if (w_accept && !w_req_err) begin
            o_ram_en  = 1'b1;
            o_ram_wen = i_req_wen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inf_valid <= 1'b0;
            r_inf_wr    <= 1'b0;
            r_inf_err   <= 1'b0;
        end else begin
            r_inf_valid <= w_accept;
            r_inf_wr    <= w_accept & w_req_wr;
            r_inf_err   <= w_accept & w_req_err;
        end
    end

    // The RAM's registered read data is valid in the cycle after the access.
    // It is captured only for a good read.
    assign w_push       = r_inf_valid;
    assign w_push_rdata = (r_inf_valid && !r_inf_wr && !r_inf_err) ? i_ram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_rdata[0] <= '0;
            r_fifo_rdata[1] <= '0;
            r_fifo_wr       <= '0;
            r_fifo_err      <= '0;
        end else if (w_push) begin
            r_fifo_rdata[r_wptr] <= w_push_rdata;
            r_fifo_wr[r_wptr]    <= r_inf_wr;
            r_fifo_err[r_wptr]   <= r_inf_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head-entry outputs are masked while the FIFO is empty, so they read 0 when idle.
    assign o_rsp_valid = w_rsp_valid;
    assign o_rsp_rdata = w_rsp_valid ? r_fifo_rdata[r_rptr] : '0;
    assign o_rsp_wr    = w_rsp_valid & r_fifo_wr[r_rptr];
    assign o_rsp_err   = w_rsp_valid & r_fifo_err[r_rptr];

endmodule
